// File: rtl/sect233k1_pt_mul_ctrl_if.sv
// Host-side request/response bundle for the sect233k1 point-multiply sequencer.
// Ports: req_valid/req_ready/req_d carry the scalar in; rsp_valid/rsp_ready with
//        rsp_x/rsp_y/rsp_err carry the affine result (or timeout error) back out.
// master = host/command fabric side, slave = sequencer side.
interface sect233k1_pt_mul_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic [232:0] req_d;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [232:0] rsp_x;
  logic [232:0] rsp_y;
  logic         rsp_err;

  modport master (
    output req_valid, req_d, rsp_ready,
    input  req_ready, rsp_valid, rsp_x, rsp_y, rsp_err
  );

  modport slave (
    input  req_valid, req_d, rsp_ready,
    output req_ready, rsp_valid, rsp_x, rsp_y, rsp_err
  );
endinterface

// File: rtl/sect233k1_pt_mul_ctrl.sv
// Purpose: sequences one sect233k1 point multiplication per request, with watchdog recovery.
// Latency: accept T -> core_start T+1 -> rsp_valid one cycle after core_done (or T+3+TIMEOUT on timeout).
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready, one bubble per op.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   clr                 : synchronous abort; in-flight op discarded without response
//   host (slave)        : request / response handshake bundle
//   busy, op_cnt        : not-IDLE flag, count of successful responses (wrapping)
//   core_rst_n          : core reset, combinational ~rst
//   core_clr/core_start : one-cycle pulses to the core
//   core_d              : scalar to the core, held from START until the next accept
//   core_done/x/y       : core completion and affine result
module sect233k1_pt_mul_ctrl #(
  parameter int TIMEOUT = 1048576,
  parameter int CNT_W   = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  sect233k1_pt_mul_ctrl_if.slave host,
  output logic                   busy,
  output logic [15:0]            op_cnt,
  output logic                   core_rst_n,
  output logic                   core_clr,
  output logic                   core_start,
  output logic [232:0]           core_d,
  input  logic                   core_done,
  input  logic [232:0]           core_x,
  input  logic [232:0]           core_y
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Counter value seen in the final WAIT cycle: it is zeroed in START and
  // first reads 0 in the first WAIT cycle, so TIMEOUT WAIT cycles end here.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e         state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic           to_resp_q, to_resp_d;   // CLEAR exit: 1 = timeout (respond), 0 = abort (silent)
  logic [232:0]   core_d_q,  core_d_d;
  logic [232:0]   rsp_x_q,   rsp_x_d;
  logic [232:0]   rsp_y_q,   rsp_y_d;
  logic           rsp_err_q, rsp_err_d;
  logic [15:0]    op_cnt_q,  op_cnt_d;

  logic           req_ready;
  logic           accept;

  // Only combinational output besides core_rst_n: ready drops the same cycle
  // rst or clr is raised so nothing is accepted while the block is being reset/aborted.
  assign req_ready = (state_q == ST_IDLE) && !rst && !clr;
  assign accept    = host.req_valid && req_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_resp_d = to_resp_q;
    core_d_d  = core_d_q;
    rsp_x_d   = rsp_x_q;
    rsp_y_d   = rsp_y_q;
    rsp_err_d = rsp_err_q;
    op_cnt_d  = op_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          core_d_d = host.req_d;
          state_d  = ST_START;
        end
      end

      ST_START: begin
        cnt_d = '0;
        if (clr) begin
          to_resp_d = 1'b0;
          state_d   = ST_CLEAR;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr) begin
          to_resp_d = 1'b0;
          state_d   = ST_CLEAR;
        end else if (core_done) begin
          // done beats a coincident timeout
          rsp_x_d   = core_x;
          rsp_y_d   = core_y;
          rsp_err_d = 1'b0;
          op_cnt_d  = op_cnt_q + 16'd1;
          state_d   = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_x_d   = '0;
          rsp_y_d   = '0;
          rsp_err_d = 1'b1;
          to_resp_d = 1'b1;
          state_d   = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        // clr is ignored here: the core is already being cleared
        state_d = to_resp_q ? ST_RESP : ST_IDLE;
      end

      ST_RESP: begin
        if (clr || host.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      to_resp_q <= 1'b0;
      core_d_q  <= '0;
      rsp_x_q   <= '0;
      rsp_y_q   <= '0;
      rsp_err_q <= 1'b0;
      op_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      to_resp_q <= to_resp_d;
      core_d_q  <= core_d_d;
      rsp_x_q   <= rsp_x_d;
      rsp_y_q   <= rsp_y_d;
      rsp_err_q <= rsp_err_d;
      op_cnt_q  <= op_cnt_d;
    end
  end

  // Everything below is a register or a pure decode of state_q.
  assign host.req_ready = req_ready;
  assign host.rsp_valid = (state_q == ST_RESP);
  assign host.rsp_x     = rsp_x_q;
  assign host.rsp_y     = rsp_y_q;
  assign host.rsp_err   = rsp_err_q;
  assign busy           = (state_q != ST_IDLE);
  assign op_cnt         = op_cnt_q;
  assign core_rst_n     = ~rst;
  assign core_clr       = (state_q == ST_CLEAR);
  assign core_start     = (state_q == ST_START);
  assign core_d         = core_d_q;

  // Pulses are single-cycle by construction; response is held while stalled.
  a_start_pulse : assert property (@(posedge clk) disable iff (rst)
    core_start |=> !core_start);
  a_clr_pulse : assert property (@(posedge clk) disable iff (rst)
    core_clr |=> !core_clr);
  a_rsp_hold : assert property (@(posedge clk) disable iff (rst)
    (host.rsp_valid && !host.rsp_ready && !clr) |=>
      (host.rsp_valid && $stable(rsp_x_q) && $stable(rsp_y_q) && $stable(rsp_err_q)));

endmodule

// File: tb/tb_sect233k1_pt_mul_ctrl.sv
// Directed bench for sect233k1_pt_mul_ctrl with TIMEOUT=16.
// Each operation is described by when core_done / clr arrive and how long
// rsp_ready is withheld; per-cycle expectations are derived from those numbers.
module tb_sect233k1_pt_mul_ctrl;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         busy;
  logic [15:0]  op_cnt;
  logic         core_rst_n;
  logic         core_clr;
  logic         core_start;
  logic [232:0] core_d;
  logic         core_done;
  logic [232:0] core_x;
  logic [232:0] core_y;

  sect233k1_pt_mul_ctrl_if bus ();

  sect233k1_pt_mul_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .host       (bus),
    .busy       (busy),
    .op_cnt     (op_cnt),
    .core_rst_n (core_rst_n),
    .core_clr   (core_clr),
    .core_start (core_start),
    .core_d     (core_d),
    .core_done  (core_done),
    .core_x     (core_x),
    .core_y     (core_y)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt;

  task automatic chk(input string tag, input logic [232:0] got, input logic [232:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // One operation, k = cycle index relative to the accept cycle (k=0).
  // dk: cycle core_done is high (-1: never); ck: cycle clr is high (-1: none);
  // stall: cycles rsp_ready is held low once rsp_valid rises.
  // Returns in the IDLE cycle without advancing, so a following call
  // accepts in the very first cycle after the handshake.
  task automatic run_op(input string tag, input logic [232:0] d, input int dk, input int ck,
                        input int stall, input logic [232:0] xv, input logic [232:0] yv);
    bit abort, succ;
    int clr_k, rs_k, idle_k;
    logic [232:0] ex, ey;
    abort  = (ck >= 1) && (dk < 0 || ck <= dk) && (ck <= 1 + TO);
    succ   = !abort && (dk >= 2) && (dk <= 1 + TO);
    clr_k  = abort ? ck + 1 : (succ ? -1 : 2 + TO);
    rs_k   = abort ? -1 : (succ ? dk + 1 : 3 + TO);
    idle_k = abort ? ck + 2 : rs_k + stall + 1;
    ex     = succ ? xv : '0;
    ey     = succ ? yv : '0;
    if (succ) exp_cnt = exp_cnt + 16'd1;

    for (int k = 0; k < idle_k; k++) begin
      bus.req_valid = (k == 0);
      bus.req_d     = (k == 0) ? d : ~d;
      core_done     = (k == dk);
      core_x        = (k == dk) ? xv : ~xv;
      core_y        = (k == dk) ? yv : ~yv;
      clr           = (k == ck);
      bus.rsp_ready = (rs_k >= 0) && (k >= rs_k + stall);
      #1;
      chk({tag, "/req_ready"}, bus.req_ready, (k == 0));
      chk({tag, "/core_start"}, core_start, (k == 1));
      chk({tag, "/core_clr"}, core_clr, (k == clr_k));
      chk({tag, "/busy"}, busy, (k >= 1));
      chk({tag, "/rsp_valid"}, bus.rsp_valid, (rs_k >= 0 && k >= rs_k));
      if (k >= 1) chk({tag, "/core_d"}, core_d, d);
      if (rs_k >= 0 && k >= rs_k) begin
        chk({tag, "/rsp_x"}, bus.rsp_x, ex);
        chk({tag, "/rsp_y"}, bus.rsp_y, ey);
        chk({tag, "/rsp_err"}, bus.rsp_err, !succ);
      end
      cyc();
    end

    bus.req_valid = 1'b0;
    core_done     = 1'b0;
    clr           = 1'b0;
    bus.rsp_ready = 1'b0;
    #1;
    chk({tag, "/idle_ready"}, bus.req_ready, 1'b1);
    chk({tag, "/idle_busy"}, busy, 1'b0);
    chk({tag, "/idle_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk({tag, "/op_cnt"}, op_cnt, exp_cnt);
  endtask

  initial begin
    rst           = 1'b1;
    clr           = 1'b0;
    core_done     = 1'b0;
    core_x        = '0;
    core_y        = '0;
    bus.req_valid = 1'b0;
    bus.req_d     = '0;
    bus.rsp_ready = 1'b0;
    exp_cnt       = '0;

    // reset values
    cyc();
    cyc();
    chk("rst/req_ready", bus.req_ready, 1'b0);
    chk("rst/core_rst_n", core_rst_n, 1'b0);
    chk("rst/rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst/busy", busy, 1'b0);
    chk("rst/core_start", core_start, 1'b0);
    chk("rst/core_clr", core_clr, 1'b0);
    chk("rst/op_cnt", op_cnt, 16'd0);
    chk("rst/core_d", core_d, 233'd0);
    chk("rst/rsp_x", bus.rsp_x, 233'd0);
    rst = 1'b0;
    #1;
    chk("post_rst/core_rst_n", core_rst_n, 1'b1);
    chk("post_rst/req_ready", bus.req_ready, 1'b1);

    // clr in IDLE blocks acceptance
    clr           = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_d     = 233'h77;
    #1;
    chk("idle_clr/req_ready", bus.req_ready, 1'b0);
    cyc();
    chk("idle_clr/busy", busy, 1'b0);
    chk("idle_clr/core_start", core_start, 1'b0);
    clr           = 1'b0;
    bus.req_valid = 1'b0;
    #1;

    run_op("nominal",   233'h1,   7,  -1, 0, 233'hABC, 233'h123);
    run_op("backpress", 233'h5,   4,  -1, 5, 233'h5555, 233'hAAAA);
    run_op("b2b",       233'h9,   2,  -1, 0, 233'h1234, 233'h5678);
    run_op("timeout",   233'h2,   -1, -1, 0, 233'h0, 233'h0);
    run_op("tmo_stall", 233'h3,   -1, -1, 2, 233'h0, 233'h0);
    run_op("race",      233'h4,   17, -1, 0, 233'hDEF, 233'h456);
    run_op("abort",     233'h6,   -1, 4,  0, 233'h0, 233'h0);
    run_op("after_abt", 233'h7,   3,  -1, 0, 233'h1F1F, 233'h2E2E);
    run_op("abort_st",  233'h8,   -1, 1,  0, 233'h0, 233'h0);
    run_op("clr_done",  233'hA,   6,  6,  0, 233'h99, 233'h88);
    run_op("wide",      {1'b1, 232'h0}, 5, -1, 1, {233{1'b1}}, {1'b1, 116'h0, 116'hFFFF});

    // reset mid-operation
    bus.req_valid = 1'b1;
    bus.req_d     = 233'hB;
    #1;
    chk("rst_mid/accept", bus.req_ready, 1'b1);
    cyc();
    bus.req_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("rst_mid/core_rst_n", core_rst_n, 1'b0);
    chk("rst_mid/req_ready", bus.req_ready, 1'b0);
    cyc();
    chk("rst_mid/busy", busy, 1'b0);
    chk("rst_mid/core_clr", core_clr, 1'b0);
    chk("rst_mid/core_start", core_start, 1'b0);
    chk("rst_mid/rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_mid/rsp_x", bus.rsp_x, 233'd0);
    chk("rst_mid/rsp_y", bus.rsp_y, 233'd0);
    chk("rst_mid/rsp_err", bus.rsp_err, 1'b0);
    chk("rst_mid/op_cnt", op_cnt, 16'd0);
    chk("rst_mid/core_d", core_d, 233'd0);
    chk("rst_mid/core_rst_n_hold", core_rst_n, 1'b0);
    rst     = 1'b0;
    exp_cnt = '0;
    cyc();
    chk("rst_mid/no_clr_after", core_clr, 1'b0);
    chk("rst_mid/idle", busy, 1'b0);

    // op_cnt wrap: preload the counter to 65535 through its next-state value
    force dut.op_cnt_d = 16'hFFFF;
    cyc();
    release dut.op_cnt_d;
    #1;
    chk("wrap/preload", op_cnt, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    run_op("wrap", 233'hC, 3, -1, 0, 233'h321, 233'h654);
    chk("wrap/zero", op_cnt, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sect233k1_pt_mul_ctrl.md
# sect233k1_pt_mul_ctrl

Initiator-side sequencer for the `sect233k1_pt_mul` core. It accepts scalar requests on a valid/ready port and drives the core's `clr`/`start`/`d` pins. It waits for `done`, captures the affine result (`x`, `y`) and returns it on a valid/ready response port. A watchdog timeout recovers the core if `done` never arrives. The block sits between a host/command fabric and the point-multiplication core.

## Interface
- `TIMEOUT`, 1048576: cycles spent in WAIT before the operation is declared failed; legal range 2..2^24.
- `CNT_W`, 24: width of the watchdog counter; must satisfy 2^CNT_W ≥ TIMEOUT.
- `clk  in  1  system clock; all logic rises on posedge`
- `rst  in  1  synchronous reset, active-high`
- `clr  in  1  synchronous abort, active-high; outstanding request discarded, no response`
- `req_valid  in  1  request valid`
- `req_ready  out  1  request ready`
- `req_d  in  233  scalar for the request`
- `rsp_valid  out  1  response valid`
- `rsp_ready  in  1  response ready`
- `rsp_x  out  233  result x; 0 on error`
- `rsp_y  out  233  result y; 0 on error`
- `rsp_err  out  1  1 = watchdog timeout`
- `busy  out  1  state ≠ IDLE`
- `op_cnt  out  16  count of successful responses; wraps at 65535→0`
- `core_rst_n  out  1  core reset, equal to ~rst (combinational)`
- `core_clr  out  1  core clear, one-cycle pulse`
- `core_start  out  1  core start, one-cycle pulse`
- `core_d  out  233  scalar to core; held stable from START until the next accept`
- `core_done  in  1  core completion`
- `core_x  in  233  core x result`
- `core_y  in  233  core y result`

## Operation
- States: IDLE, START, WAIT, CLEAR, RESP. Reset → IDLE.
- IDLE: `req_ready = 1` when `!rst && !clr`. On `req_valid && req_ready`: latch `req_d` into `core_d`, then go to START.
- START: `core_start = 1` for exactly this cycle. Watchdog counter ← 0. Go to WAIT.
- WAIT: counter increments each cycle.
  - If `core_done`: capture `core_x`/`core_y` into `rsp_x`/`rsp_y`, set `rsp_err = 0`, increment `op_cnt`, go to RESP.
  - Else if counter == TIMEOUT−1: set `rsp_x = rsp_y = 0`, set `rsp_err = 1`, go to CLEAR.
  - If `core_done` and the timeout coincide, `core_done` wins.
- CLEAR: `core_clr = 1` for this cycle only. Then go to RESP on a timeout path, or IDLE on an abort path.
- RESP: `rsp_valid = 1`. `rsp_x`, `rsp_y` and `rsp_err` stay stable until `rsp_ready`. On handshake, go to IDLE.
- `core_done` outside WAIT is ignored.
- `clr` handling, highest priority after `rst`:
  - In START or WAIT: go to CLEAR (abort path). No response, `op_cnt` unchanged.
  - In RESP: drop `rsp_valid` and go to IDLE.
  - In IDLE or CLEAR: no effect except forcing `req_ready = 0`.
- `rst` mid-operation: immediate return to IDLE. No `core_clr` pulse is issued, because `core_rst_n` resets the core.

## Timing
- Reset values:
  - `req_ready`, `rsp_valid`, `rsp_err`, `busy`, `core_clr` and `core_start` are all 0.
  - `rsp_x`, `rsp_y`, `core_d` and `op_cnt` are all 0.
  - `core_rst_n = 0` while `rst = 1`.
- Other than `req_ready` and `core_rst_n`, every output is registered or a pure decode of the state register.
- Accept at cycle T:
  - `core_start` is high in T+1.
  - WAIT is first active in T+2.
- `core_done` sampled high in cycle W: `rsp_valid` is high in W+1. Response latency = (W−T)+1.
- Timeout with no `core_done`:
  - Last WAIT cycle is T+1+TIMEOUT.
  - `core_clr` is high in T+2+TIMEOUT.
  - `rsp_valid` is high from T+3+TIMEOUT.
- `rsp_valid && rsp_ready` in cycle R: IDLE in R+1. The earliest next accept is R+1, so there is one bubble per operation.
- Only one operation is ever in flight.

## Test plan
- **Nominal** (TIMEOUT=16): accept `req_d=0x1` at T, model raises `core_done` at T+7 with x=0xABC, y=0x123, `rsp_ready=1`. Required: `core_start` only at T+1; `rsp_valid` at T+8 with x=0xABC, y=0x123, err=0; `op_cnt=1`.
- **Backpressure**: as nominal but `rsp_ready=0` for 5 cycles. Required: `rsp_*` stable for all 5 cycles, `req_ready=0` throughout; accept possible the cycle after the handshake.
- **Timeout** (TIMEOUT=16): `core_done` never asserted. Required: `core_clr` pulse at T+18; `rsp_valid` at T+19 with x=y=0, err=1; `op_cnt` unchanged.
- **Race**: `core_done` asserted in the final WAIT cycle (T+17). Required: success response at T+18, err=0, no `core_clr` pulse.
- **Abort**: `clr` at T+4 (in WAIT). Required: `core_clr` at T+5, IDLE at T+6, no `rsp_valid`; a new request afterwards completes normally.
- **Reset mid-op and wrap**: `rst` at T+3 → all outputs 0 next cycle, `core_rst_n=0` during reset. Separately, preload 65535 successes → next success gives `op_cnt=0`.
